mod_mux_final: RTL and testbench
================================

MOD_MUX_FINAL -- requirements
Module: mod_mux_final

Interface
REQ-001 Parameter nAddr, default 2, width of the read address.
REQ-002 Parameter nFlags, default 8, width of the status/flag word.
REQ-003 Parameter plaintxtL, default 128, width of the host output bus.
REQ-004 Parameter N, default 16, number of bytes in one ciphertext block.
REQ-005 The clock port SHALL be clk (input, 1 bit): single clock; all state updates on rising edge.
REQ-006 The reset port SHALL be rst (input, 1 bit): reset is synchronous and active-high.
REQ-007 addr (input, nAddr bits): read select; 0 = flags, 1 = ciphertext block, 2 = occupancy, 3 = reserved.
REQ-008 rd_en (input, 1 bit): host read strobe, sampled with addr.
REQ-009 inp0 (input, nFlags bits): live flag word from the AES core.
REQ-010 inp1 (input, N x 8 bits): ciphertext block from the AES core.
REQ-011 inp1_valid (input, 1 bit): inp1 holds a finished block.
REQ-012 inp1_ready (output, 1 bit): the block can accept inp1 this cycle.
REQ-013 outp (output, plaintxtL bits): registered read data.
REQ-014 outp_valid (output, 1 bit): outp updated by a read this cycle.

Function
REQ-015 Block push: when inp1_valid && inp1_ready at a rising edge, the block SHALL store inp1 in the buffer.
REQ-016 inp1_ready SHALL be 1 exactly when the buffer is not full; it is combinational from occupancy only.
REQ-017 Read latency: outp/outp_valid SHALL update on the edge after rd_en is sampled; outp_valid is a 1-cycle pulse per rd_en.
REQ-018 addr=0 read: outp SHALL equal {zero-extension, sticky_ovf, inp0[nFlags-2:0]} with inp0 sampled at the rd_en edge; bit nFlags-1 is replaced by the sticky overflow flag.
REQ-019 addr=1 read with a non-empty buffer: outp[8*i +: 8] SHALL equal stored byte i for i=0..N-1, and the oldest entry is popped.
REQ-020 addr=1 read with an empty buffer: outp SHALL be all zeros, outp_valid SHALL still pulse, no pop occurs, and sticky_ovf is set.
REQ-021 addr=2 read: outp SHALL equal the occupancy count, zero-extended.
REQ-022 addr=3 read: outp SHALL be all zeros with outp_valid pulsing.
REQ-023 Push and pop in the same cycle SHALL both complete; occupancy is unchanged; with a full buffer the pop frees space, but inp1_ready stays 0 that cycle, so no push occurs.
REQ-024 When inp1_valid=1 and inp1_ready=0, the block SHALL drop nothing: the core holds inp1 and the block does not store it.
REQ-025 sticky_ovf SHALL clear only on an addr=0 read, after its value is returned.
REQ-026 When rd_en=0, outp SHALL hold its last value.

Reset
REQ-027 While rst=1, the block SHALL set outp=0, outp_valid=0, occupancy=0 (inp1_ready=1), sticky_ovf=0, and buffer pointers=0.
REQ-028 When rst=1 coincides with rd_en or inp1_valid, the block SHALL ignore them; a read or push in flight is discarded.
REQ-029 Buffer data storage need not be reset.

Configuration
REQ-030 Macro MOD_MUX_FINAL_BUF2_EN: when defined, the buffer SHALL be a 2-entry FIFO with occupancy 0..2; read and write pointers wrap modulo 2.
REQ-031 When MOD_MUX_FINAL_BUF2_EN is undefined, the buffer SHALL be a single register with occupancy 0..1; all other behaviour is identical.

Verification
REQ-032 Scenario: after reset, push inp1 bytes i=0x10+i, then rd_en addr=1 -> next cycle outp=0x1F1E...1110, outp_valid=1, and a later addr=2 read returns 0.
REQ-033 Scenario: rd_en addr=1 on an empty buffer -> outp=0 and outp_valid=1; then addr=0 read with inp0=0x05 -> outp=0x85; a repeat addr=0 read -> outp=0x05.
REQ-034 Scenario (BUF2_EN): push blocks A then B, hold C valid -> inp1_ready=0 and occupancy=2; read addr=1 returns A; C is accepted the next cycle; following reads return B then C.
REQ-035 Scenario (BUF2_EN undefined): push A, hold B valid -> inp1_ready=0; in the same cycle as the pop of A, B is still not accepted; B is accepted the next cycle.
REQ-036 Scenario: assert rst for 1 cycle while rd_en=1 and inp1_valid=1 with data pending -> outp=0, outp_valid=0, occupancy=0, inp1_ready=1 on the following cycle.
REQ-037 Scenario: rd_en addr=3 -> outp=0, outp_valid=1, and occupancy is unchanged.

Source files
------------

// File: rtl/mod_mux_final.sv
// mod_mux_final: host read mux in front of an AES core.
//
// Holds finished ciphertext blocks in a small buffer and returns one of
// four registered words on a host read:
//   addr 0 : flag word, with its MSB replaced by the sticky overflow flag
//   addr 1 : oldest buffered ciphertext block (popped); zeros if empty
//   addr 2 : buffer occupancy
//   addr 3 : reserved, reads as zero
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-high reset
//   addr       - read select, sampled with rd_en
//   rd_en      - host read strobe
//   inp0       - live flag word from the AES core
//   inp1       - ciphertext block, byte i in inp1[8*i +: 8]
//   inp1_valid - inp1 holds a finished block
//   inp1_ready - buffer not full, block can be accepted this cycle
//   outp       - registered read data
//   outp_valid - one-cycle pulse per read
//
// Configuration macro MOD_MUX_FINAL_BUF2_EN:
//   defined   -> 2-entry FIFO buffer (occupancy 0..2)
//   undefined -> single block register (occupancy 0..1)
//
// Assumes plaintxtL >= 8*N, plaintxtL >= nFlags and nAddr >= 2.

module mod_mux_final #(
    parameter int unsigned nAddr     = 2,
    parameter int unsigned nFlags    = 8,
    parameter int unsigned plaintxtL = 128,
    parameter int unsigned N         = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [nAddr-1:0]     addr,
    input  logic                 rd_en,
    input  logic [nFlags-1:0]    inp0,
    input  logic [8*N-1:0]       inp1,
    input  logic                 inp1_valid,
    output logic                 inp1_ready,
    output logic [plaintxtL-1:0] outp,
    output logic                 outp_valid
);

`ifdef MOD_MUX_FINAL_BUF2_EN
    localparam int unsigned Depth = 2;
`else
    localparam int unsigned Depth = 1;
`endif

    logic [1:0]           r_count;
    logic                 r_ovf;
    logic [plaintxtL-1:0] r_outp;
    logic                 r_outp_valid;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_blk_rd;
    logic                 w_flag_rd;
    logic [8*N-1:0]       w_head;
    logic [plaintxtL-1:0] w_rd_data;

    // The flag MSB is replaced by the overflow flag and never read.
    logic w_unused_ok;
    assign w_unused_ok = inp0[nFlags-1];

    assign w_full     = (r_count == 2'(Depth));
    assign w_empty    = (r_count == 2'd0);
    assign inp1_ready = ~w_full;
    // Ready comes from the pre-edge occupancy, so a pop never makes room
    // for a push in the same cycle.
    assign w_push     = inp1_valid & ~w_full;
    assign w_blk_rd   = rd_en & (addr == nAddr'(1));
    assign w_flag_rd  = rd_en & (addr == nAddr'(0));
    assign w_pop      = w_blk_rd & ~w_empty;

`ifdef MOD_MUX_FINAL_BUF2_EN
    logic [8*N-1:0] r_mem0;
    logic [8*N-1:0] r_mem1;
    logic           r_wr_ptr;
    logic           r_rd_ptr;

    assign w_head = r_rd_ptr ? r_mem1 : r_mem0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            if (r_wr_ptr) r_mem1 <= inp1;
            else          r_mem0 <= inp1;
        end
    end
`else
    logic [8*N-1:0] r_mem0;

    assign w_head = r_mem0;

    // Push only happens when empty and pop only when full, so they never
    // collide on the single register.
    always_ff @(posedge clk) begin
        if (!rst && w_push) r_mem0 <= inp1;
    end
`endif

    always_comb begin
        w_rd_data = '0;
        case (addr)
            nAddr'(0): w_rd_data[nFlags-1:0] = {r_ovf, inp0[nFlags-2:0]};
            nAddr'(1): if (!w_empty) w_rd_data[8*N-1:0] = w_head;
            nAddr'(2): w_rd_data[1:0] = r_count;
            default:   w_rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_outp       <= '0;
            r_outp_valid <= 1'b0;
            r_count      <= 2'd0;
            r_ovf        <= 1'b0;
        end else begin
            r_outp_valid <= rd_en;
            if (rd_en) r_outp <= w_rd_data;

            // The flag read returns the old value, then clears it.
            if (w_flag_rd)                r_ovf <= 1'b0;
            else if (w_blk_rd && w_empty) r_ovf <= 1'b1;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign outp       = r_outp;
    assign outp_valid = r_outp_valid;

endmodule

// File: tb/tb_mod_mux_final.sv
// Self-checking bench for mod_mux_final: directed scenarios plus a random
// run checked against a queue-based reference model.

module tb_mod_mux_final;

    localparam int unsigned NADDR  = 2;
    localparam int unsigned NFLAGS = 8;
    localparam int unsigned PL     = 128;
    localparam int unsigned NB     = 16;
`ifdef MOD_MUX_FINAL_BUF2_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NADDR-1:0]  addr;
    logic              rd_en;
    logic [NFLAGS-1:0] inp0;
    logic [8*NB-1:0]   inp1;
    logic              inp1_valid;
    logic              inp1_ready;
    logic [PL-1:0]     outp;
    logic              outp_valid;

    always #5 clk = ~clk;

    mod_mux_final #(
        .nAddr    (NADDR),
        .nFlags   (NFLAGS),
        .plaintxtL(PL),
        .N        (NB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .rd_en     (rd_en),
        .inp0      (inp0),
        .inp1      (inp1),
        .inp1_valid(inp1_valid),
        .inp1_ready(inp1_ready),
        .outp      (outp),
        .outp_valid(outp_valid)
    );

    // Reference model: a queue of blocks plus the sticky flag.
    logic [127:0] q[$];
    logic         m_ovf;
    logic [127:0] m_outp;
    logic         m_valid;

    int n_pass  = 0;
    int n_total = 0;

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Advance model by one edge using the inputs the DUT samples, then clock.
    task automatic step();
        bit push;
        if (rst) begin
            q.delete();
            m_ovf   = 1'b0;
            m_outp  = '0;
            m_valid = 1'b0;
        end else begin
            push    = inp1_valid && (q.size() < DEPTH);
            m_valid = rd_en;
            if (rd_en) begin
                case (addr)
                    2'd0: begin
                        m_outp    = 128'(inp0[6:0]);
                        m_outp[7] = m_ovf;
                        m_ovf     = 1'b0;
                    end
                    2'd1: begin
                        if (q.size() > 0) m_outp = q.pop_front();
                        else begin
                            m_outp = '0;
                            m_ovf  = 1'b1;
                        end
                    end
                    2'd2:    m_outp = 128'(q.size());
                    default: m_outp = '0;
                endcase
            end
            if (push) q.push_back(inp1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; rd_en = 1'b0; inp1_valid = 1'b0; addr = '0; inp0 = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; rd_en = 1'b0; inp1_valid = 1'b0; addr = '0; inp0 = '0; inp1 = '0;
        step();
        step();
        idle();
        n_total++;
        if (outp !== '0) $display("FAIL reset_outp actual=%h required=0", outp);
        else n_pass++;
        n_total++;
        if (outp_valid !== 1'b0) $display("FAIL reset_valid actual=%b required=0", outp_valid);
        else n_pass++;
        n_total++;
        if (inp1_ready !== 1'b1) $display("FAIL reset_ready actual=%b required=1", inp1_ready);
        else n_pass++;
    endtask

    task automatic test_block_read();
        logic [127:0] exp_blk = 128'h1F1E1D1C1B1A19181716151413121110;
        for (int i = 0; i < 16; i++) inp1[8*i +: 8] = 8'(8'h10 + i);
        inp1_valid = 1'b1;
        step();
        inp1_valid = 1'b0;
        rd_en = 1'b1; addr = 2'd1;
        step();
        rd_en = 1'b0;
        n_total++;
        if (outp !== exp_blk || outp_valid !== 1'b1)
            $display("FAIL block_read actual=%h/%b required=%h/1", outp, outp_valid, exp_blk);
        else n_pass++;
        step();
        n_total++;
        if (outp !== exp_blk || outp_valid !== 1'b0)
            $display("FAIL hold_no_read actual=%h/%b required=%h/0", outp, outp_valid, exp_blk);
        else n_pass++;
        rd_en = 1'b1; addr = 2'd2;
        step();
        rd_en = 1'b0;
        n_total++;
        if (outp !== '0) $display("FAIL occ_after_pop actual=%h required=0", outp);
        else n_pass++;
    endtask

    task automatic test_empty_read();
        rd_en = 1'b1; addr = 2'd1;
        step();
        n_total++;
        if (outp !== '0 || outp_valid !== 1'b1)
            $display("FAIL empty_read actual=%h/%b required=0/1", outp, outp_valid);
        else n_pass++;
        addr = 2'd0; inp0 = 8'h05;
        step();
        n_total++;
        if (outp !== 128'h85) $display("FAIL sticky_ovf actual=%h required=85", outp);
        else n_pass++;
        step();
        rd_en = 1'b0;
        n_total++;
        if (outp !== 128'h05) $display("FAIL ovf_cleared actual=%h required=05", outp);
        else n_pass++;
    endtask

    task automatic test_reserved();
        inp1 = rand_blk(); inp1_valid = 1'b1;
        step();
        inp1_valid = 1'b0;
        rd_en = 1'b1; addr = 2'd3;
        step();
        n_total++;
        if (outp !== '0 || outp_valid !== 1'b1)
            $display("FAIL reserved_read actual=%h/%b required=0/1", outp, outp_valid);
        else n_pass++;
        addr = 2'd2;
        step();
        n_total++;
        if (outp !== 128'd1) $display("FAIL occ_after_reserved actual=%h required=1", outp);
        else n_pass++;
        addr = 2'd1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] blk[3];
        for (int i = 0; i < 3; i++) blk[i] = rand_blk();
        inp1_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            inp1 = blk[i];
            step();
        end
        inp1 = blk[DEPTH];
        n_total++;
        if (inp1_ready !== 1'b0) $display("FAIL full_ready actual=%b required=0", inp1_ready);
        else n_pass++;
        rd_en = 1'b1; addr = 2'd2;
        step();
        n_total++;
        if (outp !== 128'(DEPTH)) $display("FAIL full_occ actual=%h required=%0d", outp, DEPTH);
        else n_pass++;
        addr = 2'd1;
        step();
        rd_en = 1'b0;
        n_total++;
        if (outp !== blk[0]) $display("FAIL pop_first actual=%h required=%h", outp, blk[0]);
        else n_pass++;
        // The pop must not have let the held block in on the same edge.
        n_total++;
        if (inp1_ready !== 1'b1) $display("FAIL ready_after_pop actual=%b required=1", inp1_ready);
        else n_pass++;
        step();
        inp1_valid = 1'b0;
        n_total++;
        if (inp1_ready !== 1'b0) $display("FAIL held_accepted actual=%b required=0", inp1_ready);
        else n_pass++;
        rd_en = 1'b1; addr = 2'd1;
        for (int i = 1; i <= DEPTH; i++) begin
            step();
            n_total++;
            if (outp !== blk[i]) $display("FAIL drain_%0d actual=%h required=%h", i, outp, blk[i]);
            else n_pass++;
        end
        rd_en = 1'b0;
    endtask

    task automatic test_reset_inflight();
        inp1 = rand_blk(); inp1_valid = 1'b1;
        step();
        rst = 1'b1; rd_en = 1'b1; addr = 2'd1; inp1 = rand_blk();
        step();
        idle();
        n_total++;
        if (outp !== '0 || outp_valid !== 1'b0 || inp1_ready !== 1'b1)
            $display("FAIL reset_inflight actual=%h/%b/%b required=0/0/1",
                     outp, outp_valid, inp1_ready);
        else n_pass++;
        rd_en = 1'b1; addr = 2'd2;
        step();
        rd_en = 1'b0;
        n_total++;
        if (outp !== '0) $display("FAIL occ_after_reset actual=%h required=0", outp);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs = 0;
        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 49) == 0);
            rd_en      = ($urandom_range(0, 1) == 1);
            addr       = 2'($urandom_range(0, 3));
            inp0       = 8'($urandom);
            inp1       = rand_blk();
            inp1_valid = ($urandom_range(0, 2) != 0);
            step();
            n_total++;
            if (outp !== m_outp || outp_valid !== m_valid ||
                inp1_ready !== (q.size() < DEPTH)) begin
                if (errs < 10)
                    $display("FAIL random_c%0d actual=%h/%b/%b required=%h/%b/%b", c, outp,
                             outp_valid, inp1_ready, m_outp, m_valid, q.size() < DEPTH);
                errs++;
            end else n_pass++;
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_block_read();
        test_empty_read();
        test_reserved();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
